// File: rtl/reg_to_ram_pkg.sv
// Shared types and sizing helpers for the register-bank-to-frame-buffer path.
package reg_to_ram_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } seq_state_e;

  // Frame buffer depth in 32-bit words.
  function automatic int unsigned calc_depth(input int unsigned reg_num,
                                             input int unsigned buf_num);
    return reg_num * buf_num;
  endfunction

  // Width of the word-select index; never narrower than one bit.
  function automatic int unsigned sel_width(input int unsigned reg_num);
    return (reg_num > 1) ? $clog2(reg_num) : 1;
  endfunction

  // Address width needed to index a RAM of the given depth.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/reg_to_ram_dpram.sv
// Simple dual-port frame buffer RAM: one synchronous write port, one synchronous
// read port with a clearable output register; a same-cycle collision reads old data.
module reg_to_ram_dpram
  import reg_to_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  word_t         wr_data_i,
  input  logic          rd_en_i,
  input  logic          rd_clr_i,
  input  logic [AW-1:0] rd_addr_i,
  output word_t         rd_data_o
);

  word_t mem_q [DEPTH];
  word_t rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register holds until the next read; clear serves reset and out-of-range reads.
  always_ff @(posedge clk) begin
    if (rd_clr_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/reg_to_ram.sv
// Serialises a bank of 32-bit registers into one frame slot of a circular RAM and
// exposes the RAM on a bus read port. REG2RAM_SNAPSHOT_EN adds a frame-coherent shadow copy.
module reg_to_ram
  import reg_to_ram_pkg::*;
#(
  parameter  int unsigned REG_NUM = 83,
  parameter  int unsigned BUF_NUM = 80,
  localparam int unsigned SEL_W   = sel_width(REG_NUM)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WORD_W*REG_NUM-1:0] seq_reg_i,
  input  logic [ADDR_W-1:0]         write_addr_i,
  input  logic                      write_trigger_i,
  input  logic                      write_rst_i,
  output logic [SEL_W-1:0]          select_o,
  output logic                      write_busy_o,
  input  logic [ADDR_W-1:0]         reg_addr_i,
  input  logic                      reg_rd_i,
  input  logic                      reg_wr_i,
  output logic [WORD_W-1:0]         reg_readdata_o,
  output logic                      reg_ready_o
);

  localparam int unsigned DEPTH  = calc_depth(REG_NUM, BUF_NUM);
  localparam int unsigned RAM_AW = addr_width(DEPTH);
  localparam int unsigned WA_W   = ADDR_W + 1;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(REG_NUM - 1);
  localparam logic [WA_W-1:0]  DEPTH_WA = WA_W'(DEPTH);

  seq_state_e        state_q, state_d;
  logic [SEL_W-1:0]  select_q, select_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              accept_c;

  logic [WA_W-1:0]   wr_addr_full_c;
  logic              wr_en_c;
  word_t             wr_data_c;
  word_t             src_words [REG_NUM];

  logic              rd_in_range_c;
  logic              rd_en_c;
  logic              rd_clr_c;
  logic              reg_ready_q;

  // A trigger is only honoured between frames; pulses during a frame are dropped.
  assign accept_c = (state_q == ST_IDLE) && write_trigger_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      select_q <= '0;
      base_q   <= '0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      base_q   <= base_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    base_d   = base_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          state_d  = ST_BUSY;
          select_d = '0;
          base_d   = write_addr_i;
        end
      end
      ST_BUSY: begin
        if (write_rst_i || (select_q == SEL_LAST)) begin
          state_d  = ST_IDLE;
          select_d = '0;
        end else begin
          select_d = select_q + SEL_W'(1);
        end
      end
    endcase
  end

  assign select_o     = select_q;
  assign write_busy_o = (state_q == ST_BUSY);

`ifdef REG2RAM_SNAPSHOT_EN
  logic [WORD_W*REG_NUM-1:0] shadow_q;

  // Whole bank captured on the accepted trigger so the frame is coherent.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      shadow_q <= seq_reg_i;
    end
  end

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_word
    assign src_words[gi] = shadow_q[WORD_W*gi +: WORD_W];
  end
`else
  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_word
    assign src_words[gi] = seq_reg_i[WORD_W*gi +: WORD_W];
  end
`endif

  // Extra address bit keeps base+i from wrapping before the depth check.
  assign wr_addr_full_c = {1'b0, base_q} + WA_W'(select_q);
  assign wr_en_c        = (state_q == ST_BUSY) && (wr_addr_full_c < DEPTH_WA);
  assign wr_data_c      = src_words[select_q];

  assign rd_in_range_c = ({1'b0, reg_addr_i} < DEPTH_WA);
  assign rd_en_c       = reg_rd_i && rd_in_range_c;
  assign rd_clr_c      = rst || (reg_rd_i && !rd_in_range_c);

  reg_to_ram_dpram #(
    .DEPTH (DEPTH),
    .AW    (RAM_AW)
  ) u_dpram (
    .clk       (clk),
    .wr_en_i   (wr_en_c),
    .wr_addr_i (RAM_AW'(wr_addr_full_c)),
    .wr_data_i (wr_data_c),
    .rd_en_i   (rd_en_c),
    .rd_clr_i  (rd_clr_c),
    .rd_addr_i (RAM_AW'(reg_addr_i)),
    .rd_data_o (reg_readdata_o)
  );

  // Every strobe, read or write, earns a one-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_ready_q <= 1'b0;
    end else begin
      reg_ready_q <= reg_rd_i || reg_wr_i;
    end
  end

  assign reg_ready_o = reg_ready_q;

endmodule

// File: tb/tb_reg_to_ram.sv
// Directed bench for reg_to_ram (REG_NUM=4, BUF_NUM=3) with a cycle-level reference
// model compared every cycle plus hand-computed literal expectations.
module tb_reg_to_ram;

  localparam int RN    = 4;
  localparam int BN    = 3;
  localparam int DEPTH = RN * BN;

  logic          clk = 1'b0;
  logic          rst;
  logic [127:0]  seq_reg;
  logic [15:0]   write_addr;
  logic          write_trigger;
  logic          write_rst;
  logic [1:0]    select;
  logic          write_busy;
  logic [15:0]   reg_addr;
  logic          reg_rd;
  logic          reg_wr;
  logic [31:0]   reg_readdata;
  logic          reg_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int sel3_total = 0;

  reg_to_ram #(.REG_NUM(RN), .BUF_NUM(BN)) dut (
    .clk             (clk),
    .rst             (rst),
    .seq_reg_i       (seq_reg),
    .write_addr_i    (write_addr),
    .write_trigger_i (write_trigger),
    .write_rst_i     (write_rst),
    .select_o        (select),
    .write_busy_o    (write_busy),
    .reg_addr_i      (reg_addr),
    .reg_rd_i        (reg_rd),
    .reg_wr_i        (reg_wr),
    .reg_readdata_o  (reg_readdata),
    .reg_ready_o     (reg_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: frame timing derived from the trigger cycle, RAM as a plain array.
  logic [31:0]  mmem [DEPTH];
  bit           frm_on   = 1'b0;
  bit           model_ok = 1'b0;
  int           t_trig   = 0;
  int           mbase    = 0;
  int           cyc      = 0;
  logic [127:0] snap     = '0;
  logic         exp_busy  = 1'b0;
  logic [1:0]   exp_sel   = 2'd0;
  logic         exp_ready = 1'b0;
  logic [31:0]  exp_rdata = 32'h0;

  always @(posedge clk) begin
    int k;
    int wa;
    logic [31:0] wd;
    k  = cyc - t_trig - 1;
    wa = mbase + k;
    if (rst) begin
      exp_ready = 1'b0;
      exp_rdata = 32'h0;
    end else begin
      exp_ready = reg_rd || reg_wr;
      if (reg_rd) exp_rdata = (int'(reg_addr) < DEPTH) ? mmem[reg_addr] : 32'h0;
    end
    if (frm_on) begin
`ifdef REG2RAM_SNAPSHOT_EN
      wd = snap[32*k +: 32];
`else
      wd = seq_reg[32*k +: 32];
`endif
      if (wa < DEPTH) mmem[wa] = wd;
      if (rst || write_rst || k == RN - 1) frm_on = 1'b0;
    end else if (write_trigger && !rst) begin
      frm_on = 1'b1;
      t_trig = cyc;
      mbase  = int'(write_addr);
      snap   = seq_reg;
    end
    if (rst) begin
      frm_on   = 1'b0;
      model_ok = 1'b1;
    end
    exp_busy = frm_on;
    exp_sel  = frm_on ? 2'(cyc - t_trig) : 2'd0;
    cyc++;
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("m_busy",   32'(write_busy), 32'(exp_busy));
      chk("m_select", 32'(select),     32'(exp_sel));
      chk("m_ready",  32'(reg_ready),  32'(exp_ready));
      chk("m_rdata",  reg_readdata,    exp_rdata);
      if (select == 2'd3) sel3_total++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    seq_reg = {w3, w2, w1, w0};
  endtask

  // Full uninterrupted frame with literal select/busy checks each cycle.
  task automatic run_frame(input logic [15:0] base, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
    set_words(w0, w1, w2, w3);
    write_addr    = base;
    write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    for (int i = 0; i < RN; i++) begin
      chk("frm_sel",  32'(select), 32'(i));
      chk("frm_busy", 32'(write_busy), 32'd1);
      tick();
    end
    chk("frm_end_busy", 32'(write_busy), 32'd0);
    chk("frm_end_sel",  32'(select), 32'd0);
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [31:0] e);
    reg_rd   = 1'b1;
    reg_addr = a;
    tick();
    reg_rd = 1'b0;
    chk($sformatf("rd_ready@%0d", a), 32'(reg_ready), 32'd1);
    chk($sformatf("rd_data@%0d", a), reg_readdata, e);
  endtask

  initial begin
    int s3;
    rst = 1'b1; seq_reg = '0; write_addr = '0; write_trigger = 1'b0; write_rst = 1'b0;
    reg_addr = '0; reg_rd = 1'b0; reg_wr = 1'b0;
    tick();
    tick();
    chk("rst_busy",  32'(write_busy), 32'd0);
    chk("rst_sel",   32'(select), 32'd0);
    chk("rst_ready", 32'(reg_ready), 32'd0);
    chk("rst_rdata", reg_readdata, 32'h0);
    rst = 1'b0;

    // Preload every slot with 0xA0+address so later reads are fully predictable.
    run_frame(16'd0, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
    run_frame(16'd4, 32'hA4, 32'hA5, 32'hA6, 32'hA7);
    run_frame(16'd8, 32'hA8, 32'hA9, 32'hAA, 32'hAB);

    // Plain frame write then back-to-back readback.
    run_frame(16'd4, 32'h11, 32'h22, 32'h33, 32'h44);
    read_chk(16'd4, 32'h11);
    read_chk(16'd5, 32'h22);
    read_chk(16'd6, 32'h33);
    read_chk(16'd7, 32'h44);

    // Second trigger mid-frame (pointing at slot 8) must be dropped.
    s3 = sel3_total;
    set_words(32'h55, 32'h66, 32'h77, 32'h88);
    write_addr = 16'd0; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    tick();
    write_addr = 16'd8; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    repeat (3) tick();
    chk("busy_trig_sel3_once", 32'(sel3_total - s3), 32'd1);
    chk("busy_trig_idle", 32'(write_busy), 32'd0);
    read_chk(16'd0, 32'h55);
    read_chk(16'd1, 32'h66);
    read_chk(16'd2, 32'h77);
    read_chk(16'd3, 32'h88);
    tick();
    chk("ready_drops", 32'(reg_ready), 32'd0);

    // Abort at T+2: only words 0 and 1 land.
    set_words(32'hC1, 32'hC2, 32'hC3, 32'hC4);
    write_addr = 16'd8; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    tick();
    write_rst = 1'b1;
    tick();
    write_rst = 1'b0;
    chk("abort_busy", 32'(write_busy), 32'd0);
    chk("abort_sel",  32'(select), 32'd0);
    repeat (3) tick();
    read_chk(16'd8,  32'hC1);
    read_chk(16'd9,  32'hC2);
    read_chk(16'd10, 32'hAA);
    read_chk(16'd11, 32'hAB);

    // Source words change from cycle T+3 onward.
    set_words(32'hD1, 32'hD2, 32'hD3, 32'hD4);
    write_addr = 16'd4; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    tick();
    tick();
    set_words(32'hE1, 32'hE2, 32'hE3, 32'hE4);
    repeat (3) tick();
    read_chk(16'd4, 32'hD1);
    read_chk(16'd5, 32'hD2);
`ifdef REG2RAM_SNAPSHOT_EN
    read_chk(16'd6, 32'hD3);
    read_chk(16'd7, 32'hD4);
`else
    read_chk(16'd6, 32'hE3);
    read_chk(16'd7, 32'hE4);
`endif

    // Bus edge cases: out of range, write-only strobe, read+write together.
    read_chk(16'd12, 32'h0);
    reg_wr = 1'b1; reg_addr = 16'd5;
    tick();
    reg_wr = 1'b0;
    chk("wr_ready", 32'(reg_ready), 32'd1);
    chk("wr_hold",  reg_readdata, 32'h0);
    read_chk(16'd5, 32'hD2);
    reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = 16'd6;
    tick();
    reg_rd = 1'b0; reg_wr = 1'b0;
    chk("rdwr_ready", 32'(reg_ready), 32'd1);
`ifdef REG2RAM_SNAPSHOT_EN
    chk("rdwr_data", reg_readdata, 32'hD3);
`else
    chk("rdwr_data", reg_readdata, 32'hE3);
`endif

    // Read of the word being written in the same cycle returns the old value.
    set_words(32'hF1, 32'hF2, 32'hF3, 32'hF4);
    write_addr = 16'd0; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    reg_rd = 1'b1; reg_addr = 16'd0;
    tick();
    reg_rd = 1'b0;
    chk("collide_old", reg_readdata, 32'h55);
    repeat (4) tick();
    read_chk(16'd0, 32'hF1);
    read_chk(16'd1, 32'hF2);

    // Reset mid-frame clears sequencer and bus outputs.
    read_chk(16'd4, 32'hD1);
    set_words(32'h91, 32'h92, 32'h93, 32'h94);
    write_addr = 16'd8; write_trigger = 1'b1;
    tick();
    write_trigger = 1'b0;
    tick();
    rst = 1'b1; reg_rd = 1'b1; reg_addr = 16'd2;
    tick();
    rst = 1'b0; reg_rd = 1'b0;
    chk("mrst_sel",   32'(select), 32'd0);
    chk("mrst_busy",  32'(write_busy), 32'd0);
    chk("mrst_ready", 32'(reg_ready), 32'd0);
    chk("mrst_rdata", reg_readdata, 32'h0);
    repeat (3) tick();
    read_chk(16'd8,  32'h91);
    read_chk(16'd9,  32'h92);
    read_chk(16'd10, 32'hAA);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_to_ram.md
# reg_to_ram

Serialises a wide bank of 32-bit registers into one frame slot of an on-chip circular frame buffer, one word per clock, and exposes that buffer to a register-bus read port. It sits between the per-frame accumulator/sync outputs and the bus slave in the IQ buffering path. The parent controller supplies the frame base address and advances it when `select` reaches the last word.

## Interface
- `REG_NUM`, default 83: 32-bit words per frame; `seq_reg` width is `32*REG_NUM`.
- `BUF_NUM`, default 80: frame slots; RAM depth `DEPTH = REG_NUM*BUF_NUM` words.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset; clock `clk`.
- `seq_reg` in `32*REG_NUM`: word i is bits `[32*i+31:32*i]`.
- `write_addr` in 16: frame base word address, a multiple of `REG_NUM`.
- `write_trigger` in 1: single-cycle start-of-frame pulse.
- `write_rst` in 1: aborts the frame sequence in progress.
- `select` out `$clog2(REG_NUM)`: index of the word being written; 0 when idle.
- `write_busy` out 1: high while the sequence runs.
- `reg_addr` in 16: bus word address (word index, not byte).
- `reg_rd` in 1: read strobe, one cycle.
- `reg_wr` in 1: write strobe; acknowledged, no effect.
- `reg_readdata` out 32: read data.
- `reg_ready` out 1: one-cycle acknowledge.

## Operation
- Idle: `write_busy=0`, `select=0`. A `write_trigger` pulse while idle latches `write_addr` into `base` and starts the sequence. A trigger while busy is dropped.
- Sequence: on each of `REG_NUM` consecutive cycles i = 0..REG_NUM-1, `select=i`, and word i is written to RAM address `base+i`. After word `REG_NUM-1`, return to idle.
- If `base+i >= DEPTH`, that word's write is suppressed. The sequence still runs to completion.
- `write_rst`, while busy, aborts the sequence: next cycle `write_busy=0`, `select=0`, and no further words are written. Words already written remain. While idle, `write_rst` has no effect.
- `rst` has the same effect as `write_rst` and also clears the bus outputs.
- RAM contents are not reset.
- Bus read: when `reg_rd` is high, the RAM is read at `reg_addr`. If `reg_addr >= DEPTH`, the data is 0.
- Bus write: `reg_wr` produces a `reg_ready` pulse and nothing else.
- `reg_rd` and `reg_wr` high together are treated as a read.
- Reads and the frame sequence proceed concurrently. A read of the address being written in the same cycle returns the old word.
- Reset values: `select=0`, `write_busy=0`, `reg_ready=0`, `reg_readdata=0`.

## Timing
- Trigger sampled at cycle T:
  - cycles T+1 … T+REG_NUM: `write_busy=1`, `select=i` at cycle T+1+i, RAM write in the same cycle.
  - cycle T+REG_NUM+1: `write_busy=0`, `select=0`; a new trigger is accepted in this cycle.
- `select == REG_NUM-1` lasts exactly one cycle per completed frame. The parent advances `write_addr` on it.
- Abort: `write_rst` at cycle A gives `write_busy=0` at A+1.
- Bus: strobe at cycle N gives `reg_ready=1` for exactly cycle N+1, with `reg_readdata` valid. `reg_readdata` holds until the next read completes.
- The bus may issue one strobe per cycle; each gets its own ready pulse.

## Configuration
- `REG2RAM_SNAPSHOT_EN` defined: all of `seq_reg` is copied into a shadow register on the accepted trigger. Words are taken from the shadow, giving a coherent frame.
- Not defined: word i is taken live from `seq_reg` at cycle T+1+i. No shadow storage is built.

## Structure
- Shared package holds:
  - a function computing `DEPTH` from `REG_NUM` and `BUF_NUM`;
  - the select width `$clog2(REG_NUM)`;
  - the 32-bit word typedef.
- One sub-module, `reg_to_ram_dpram`: simple dual-port RAM with one synchronous write port and one synchronous read port, `DEPTH` x 32, read-old-data on collision.
- Sequencer, optional snapshot, and bus acknowledge stay in the top.

## Test plan
All scenarios use REG_NUM=4, BUF_NUM=3.
- Frame write: `seq_reg` words {0x11,0x22,0x33,0x44}, `write_addr=4`, trigger at T → `select` 0..3 over T+1..T+4, `write_busy` low at T+5. Bus reads of addresses 4..7 return 0x11..0x44, each with `reg_ready` one cycle after `reg_rd`.
- Trigger while busy: second pulse at T+2 → ignored; exactly 4 writes; `select=3` appears once.
- Abort: `write_rst` at T+2 → `write_busy=0` at T+3; only words 0–1 written; addresses base+2 and base+3 keep old data.
- Snapshot: change `seq_reg` at T+2 with macro defined → RAM holds the pre-trigger words. Without the macro, words 2–3 are the new values.
- Bus edge cases:
  - `reg_addr=12` (out of range) → `reg_readdata=0`, ready pulse;
  - `reg_wr` → ready pulse, RAM unchanged;
  - back-to-back reads of addresses 0 and 1 → two consecutive ready pulses.
- Reset mid-frame: `rst` at T+2 → next cycle `select=0`, `write_busy=0`, `reg_ready=0`, `reg_readdata=0`.
